// File: rtl/shift_reg_pipe_pkg.sv
// Shared mode encodings and the occupancy-width helper for the shift_reg_pipe block.
package shift_reg_pkg;

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_SHIFT = 2'b01;
    localparam logic [1:0] MODE_LOAD  = 2'b10;
    localparam logic [1:0] MODE_CLEAR = 2'b11;

    // Bits needed to count 0..depth inclusive.
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/shift_reg_pipe_if.sv
// Control/data bundle for shift_reg_pipe; optional tap ports appear when SHIFT_REG_TAP_EN is defined.
interface shift_reg_pipe_if
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 10
);
    localparam int CNT_W = occ_w(DEPTH);
    localparam int SEL_W = $clog2(DEPTH);

    logic [1:0]             mode;
    logic [WIDTH-1:0]       in_data;
    logic                   in_valid;
    logic [WIDTH*DEPTH-1:0] load_data;
    logic [WIDTH-1:0]       out_data;
    logic                   out_valid;
    logic [WIDTH*DEPTH-1:0] par_data;
    logic [CNT_W-1:0]       occ;
    logic                   full;
    logic                   empty;
`ifdef SHIFT_REG_TAP_EN
    logic [SEL_W-1:0]       tap_sel;
    logic [WIDTH-1:0]       tap_data;
    logic                   tap_valid;
`endif

    modport master (
        output mode, in_data, in_valid, load_data,
`ifdef SHIFT_REG_TAP_EN
        output tap_sel,
        input  tap_data, tap_valid,
`endif
        input  out_data, out_valid, par_data, occ, full, empty
    );

    modport slave (
        input  mode, in_data, in_valid, load_data,
`ifdef SHIFT_REG_TAP_EN
        input  tap_sel,
        output tap_data, tap_valid,
`endif
        output out_data, out_valid, par_data, occ, full, empty
    );

endinterface

// File: rtl/shift_reg_pipe_shift_stage.sv
// One {data, valid} stage of the chain: clear beats load, load beats shift, otherwise hold.
module shift_stage #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic [WIDTH-1:0] shift_data_i,
    input  logic             shift_valid_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    // NOTE: next-state defaults to the current state first, so no path leaves data_d/valid_d unassigned and no latch is inferred.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (clr_i) begin
            data_d  = '0;
            valid_d = 1'b0;
        end else if (load_i) begin
            data_d  = load_data_i;
            valid_d = 1'b1;
        end else if (shift_i) begin
            data_d  = shift_data_i;
            valid_d = shift_valid_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples its neighbour's pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/shift_reg_pipe.sv
// DEPTH-stage, WIDTH-bit shift chain with HOLD/SHIFT/LOAD/CLEAR modes and occupancy count.
// Optional stage tap outputs are enabled by defining SHIFT_REG_TAP_EN.
module shift_reg_pipe
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 10
) (
    input logic            clk,
    input logic            rst,
    shift_reg_pipe_if.slave bus
);

    localparam int CNT_W = occ_w(DEPTH);
    localparam logic [CNT_W-1:0] OCC_FULL    = CNT_W'(DEPTH);
    localparam logic [CNT_W:0]   OCC_MAX_SUM = (CNT_W + 1)'(DEPTH);

    logic [WIDTH-1:0] stage_data  [DEPTH];
    logic             stage_valid [DEPTH];

    logic clr, load, shift;
    assign clr   = (bus.mode == MODE_CLEAR);
    assign load  = (bus.mode == MODE_LOAD);
    assign shift = (bus.mode == MODE_SHIFT);

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] prev_data;
        logic             prev_valid;
        if (k == 0) begin : g_head
            assign prev_data  = bus.in_data;
            assign prev_valid = bus.in_valid;
        end else begin : g_body
            assign prev_data  = stage_data[k-1];
            assign prev_valid = stage_valid[k-1];
        end

        shift_stage #(.WIDTH(WIDTH)) u_stage (
            .clk          (clk),
            .rst          (rst),
            .clr_i        (clr),
            .load_i       (load),
            .shift_i      (shift),
            .load_data_i  (bus.load_data[k*WIDTH +: WIDTH]),
            .shift_data_i (prev_data),
            .shift_valid_i(prev_valid),
            .data_o       (stage_data[k]),
            .valid_o      (stage_valid[k])
        );
    end

    logic [CNT_W-1:0] occ_q, occ_d;
    logic [CNT_W:0]   occ_sum;

    // One spare bit so the +in/-out arithmetic can never wrap silently.
    always_comb begin
        occ_sum = {1'b0, occ_q} + {{CNT_W{1'b0}}, bus.in_valid}
                                - {{CNT_W{1'b0}}, stage_valid[DEPTH-1]};
    end

    always_comb begin
        occ_d = occ_q;
        case (bus.mode)
            MODE_SHIFT: occ_d = occ_sum[CNT_W-1:0];
            MODE_LOAD:  occ_d = OCC_FULL;
            MODE_CLEAR: occ_d = '0;
            default:    occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) occ_q <= '0;
        else     occ_q <= occ_d;
    end

    occ_bound_a: assert property (@(posedge clk) disable iff (rst)
        (occ_sum <= OCC_MAX_SUM) && (occ_q <= OCC_FULL));

    logic [WIDTH*DEPTH-1:0] par;
    always_comb begin
        par = '0;
        for (int k = 0; k < DEPTH; k++) par[k*WIDTH +: WIDTH] = stage_data[k];
    end

    assign bus.par_data  = par;
    assign bus.out_data  = stage_data[DEPTH-1];
    assign bus.out_valid = stage_valid[DEPTH-1];
    assign bus.occ       = occ_q;
    assign bus.full      = (occ_q == OCC_FULL);
    assign bus.empty     = (occ_q == '0);

`ifdef SHIFT_REG_TAP_EN
    logic [WIDTH-1:0] tap_data_q, tap_data_d;
    logic             tap_valid_q, tap_valid_d;

    // Samples the stage as it stands before this edge, so the tap trails the chain by one cycle.
    always_comb begin
        tap_data_d  = '0;
        tap_valid_d = 1'b0;
        if (int'(bus.tap_sel) < DEPTH) begin
            tap_data_d  = stage_data[bus.tap_sel];
            tap_valid_d = stage_valid[bus.tap_sel];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tap_data_q  <= '0;
            tap_valid_q <= 1'b0;
        end else begin
            tap_data_q  <= tap_data_d;
            tap_valid_q <= tap_valid_d;
        end
    end

    assign bus.tap_data  = tap_data_q;
    assign bus.tap_valid = tap_valid_q;
`endif

endmodule

// File: tb/tb_shift_reg_pipe.sv
// Randomised bench for shift_reg_pipe against an array-level reference model, plus pinned literal cases.
module tb_shift_reg_pipe;
    import shift_reg_pkg::*;

    localparam int W = 1;
    localparam int D = 10;
    localparam int CW = occ_w(D);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shift_reg_pipe_if #(.WIDTH(W), .DEPTH(D)) bus ();

    shift_reg_pipe #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    bit model_ok = 1'b0;

    // Reference model: plain arrays of stage contents.
    bit [W-1:0] m_data [D];
    bit         m_vld  [D];
    bit [W-1:0] m_tap_data;
    bit         m_tap_vld;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_occ();
        int n = 0;
        for (int k = 0; k < D; k++) n += int'(m_vld[k]);
        return n;
    endfunction

    function automatic logic [W*D-1:0] m_par();
        logic [W*D-1:0] p = '0;
        for (int k = 0; k < D; k++) p[k*W +: W] = m_data[k];
        return p;
    endfunction

    always @(negedge clk) begin
        if (model_ok) begin
            check("out_data",  64'(bus.out_data),  64'(m_data[D-1]));
            check("out_valid", 64'(bus.out_valid), 64'(m_vld[D-1]));
            check("par_data",  64'(bus.par_data),  64'(m_par()));
            check("occ",       64'(bus.occ),       64'(m_occ()));
            check("full",      64'(bus.full),      64'(m_occ() == D));
            check("empty",     64'(bus.empty),     64'(m_occ() == 0));
`ifdef SHIFT_REG_TAP_EN
            check("tap_data",  64'(bus.tap_data),  64'(m_tap_data));
            check("tap_valid", 64'(bus.tap_valid), 64'(m_tap_vld));
`endif
        end
    end

    task automatic cycle(input logic [1:0] md, input logic [W-1:0] d, input logic v,
                         input logic [W*D-1:0] ld, input logic r);
        bit [W-1:0] nd [D];
        bit         nv [D];
        bit [W-1:0] ntd;
        bit         ntv;
        int         sel;
        bus.mode      = md;
        bus.in_data   = d;
        bus.in_valid  = v;
        bus.load_data = ld;
        rst           = r;
        nd = m_data;
        nv = m_vld;
        if (r || md == MODE_CLEAR) begin
            for (int k = 0; k < D; k++) begin nd[k] = '0; nv[k] = 1'b0; end
        end else if (md == MODE_SHIFT) begin
            for (int k = D - 1; k > 0; k--) begin nd[k] = m_data[k-1]; nv[k] = m_vld[k-1]; end
            nd[0] = d;
            nv[0] = v;
        end else if (md == MODE_LOAD) begin
            for (int k = 0; k < D; k++) begin nd[k] = ld[k*W +: W]; nv[k] = 1'b1; end
        end
        ntd = '0;
        ntv = 1'b0;
`ifdef SHIFT_REG_TAP_EN
        sel = int'(bus.tap_sel);
        if (!r && sel < D) begin ntd = m_data[sel]; ntv = m_vld[sel]; end
`else
        sel = 0;
`endif
        @(posedge clk);
        #1;
        m_data = nd;
        m_vld  = nv;
        m_tap_data = ntd;
        m_tap_vld  = ntv;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        cycle(MODE_HOLD, '0, 1'b0, '0, 1'b1);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [9:0]      pat;
        logic [W*D-1:0]  lit;
        logic [95:0]     rnd;
        logic [1:0]      md;
        int              pick;
        bus.mode = MODE_HOLD;
        bus.in_data = '0;
        bus.in_valid = 1'b0;
        bus.load_data = '0;
`ifdef SHIFT_REG_TAP_EN
        bus.tap_sel = '0;
`endif
        do_reset();
        model_ok = 1'b1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_empty",     64'(bus.empty),     64'd1);
        check("rst_occ",       64'(bus.occ),       64'd0);

        // Fill with 1,0,1,1,0,0,1,0,1,1 (first bit listed first).
        pat = 10'b1101001101;
        for (int e = 1; e <= 10; e++) begin
            cycle(MODE_SHIFT, W'(pat[e-1]), 1'b1, '0, 1'b0);
            check("fill_out_valid", 64'(bus.out_valid), 64'(e == 10));
            check("fill_occ",       64'(bus.occ),       64'(e));
        end
        check("fill_out_data", 64'(bus.out_data), 64'd1);
        check("fill_full",     64'(bus.full),     64'd1);
        cycle(MODE_SHIFT, '0, 1'b1, '0, 1'b0);
        check("full_steady", 64'(bus.full), 64'd1);

        // Single valid 1 followed by invalid zeros.
        do_reset();
        for (int e = 1; e <= 11; e++) begin
            cycle(MODE_SHIFT, W'(e == 1), e == 1, '0, 1'b0);
            check("single_out_data", 64'(bus.out_data), 64'(e == 10));
            check("single_occ",      64'(bus.occ),      64'(e <= 10));
        end
        check("single_empty", 64'(bus.empty), 64'd1);

        // HOLD adds no latency and freezes par_data.
        do_reset();
        cycle(MODE_SHIFT, 1'b1, 1'b1, '0, 1'b0);
        for (int h = 0; h < 5; h++) begin
            cycle(MODE_HOLD, 1'b0, 1'b1, '1, 1'b0);
            check("hold_par", 64'(bus.par_data), 64'h001);
        end
        for (int e = 2; e <= 10; e++) begin
            cycle(MODE_SHIFT, 1'b0, 1'b0, '0, 1'b0);
            check("hold_out_data", 64'(bus.out_data), 64'(e == 10));
        end

        // Parallel load then drain.
        lit = 10'h2A5;
        cycle(MODE_LOAD, '0, 1'b0, lit, 1'b0);
        check("load_out_data", 64'(bus.out_data), 64'(lit[9]));
        check("load_occ",      64'(bus.occ),      64'd10);
        for (int k = 1; k <= 10; k++) begin
            cycle(MODE_SHIFT, '0, 1'b0, '0, 1'b0);
            if (k <= 9) check("drain_out_data", 64'(bus.out_data), 64'(lit[9-k]));
            check("drain_occ", 64'(bus.occ), 64'(10 - k));
        end

        // CLEAR mid-stream, then reset against LOAD.
        for (int k = 0; k < 6; k++) cycle(MODE_SHIFT, W'($urandom), 1'b1, '0, 1'b0);
        check("pre_clear_occ", 64'(bus.occ), 64'd6);
        cycle(MODE_CLEAR, 1'b1, 1'b1, '1, 1'b0);
        check("clear_occ", 64'(bus.occ),      64'd0);
        check("clear_par", 64'(bus.par_data), 64'd0);
        cycle(MODE_LOAD, '0, 1'b0, 10'h3FF, 1'b0);
        cycle(MODE_LOAD, '0, 1'b0, 10'h3FF, 1'b1);
        rst = 1'b0;
        check("rst_beats_load_par",   64'(bus.par_data), 64'd0);
        check("rst_beats_load_empty", 64'(bus.empty),    64'd1);

`ifdef SHIFT_REG_TAP_EN
        cycle(MODE_LOAD, '0, 1'b0, 10'h2AD, 1'b0);
        bus.tap_sel = 4'd3;
        cycle(MODE_HOLD, '0, 1'b0, '0, 1'b0);
        check("tap3_data",  64'(bus.tap_data),  64'd1);
        check("tap3_valid", 64'(bus.tap_valid), 64'd1);
        bus.tap_sel = 4'd12;
        cycle(MODE_HOLD, '0, 1'b0, '0, 1'b0);
        check("tap12_data",  64'(bus.tap_data),  64'd0);
        check("tap12_valid", 64'(bus.tap_valid), 64'd0);
`endif

        // Randomised traffic, occasional reset.
        for (int i = 0; i < 800; i++) begin
            pick = $urandom_range(0, 99);
            if (pick < 55)      md = MODE_SHIFT;
            else if (pick < 80) md = MODE_HOLD;
            else if (pick < 93) md = MODE_LOAD;
            else                md = MODE_CLEAR;
            rnd = {$urandom, $urandom, $urandom};
`ifdef SHIFT_REG_TAP_EN
            bus.tap_sel = 4'($urandom_range(0, 15));
`endif
            cycle(md, W'($urandom), 1'($urandom), rnd[W*D-1:0], $urandom_range(0, 59) == 0);
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_reg_pipe.md
Name: shift_reg_pipe

Overview:
Parametrised serial shift register chain, WIDTH bits wide and DEPTH stages deep. Each stage carries a valid bit alongside its data. The block supports hold, shift, parallel load and clear modes, and keeps a running occupancy count. It sits wherever a fixed-length delay line or a serial-to-parallel buffer is needed. Defaults (WIDTH=1, DEPTH=10) give a 10-stage single-bit delay line.

Parameters:
WIDTH, 1, data bits per stage (>=1)
DEPTH, 10, number of stages (>=2)

Ports:
clk  input  1  clock; all state updates on its rising edge
rst  input  1  reset; synchronous, active-high
mode  input  2  operation select: 00 HOLD, 01 SHIFT, 10 LOAD, 11 CLEAR
in_data  input  WIDTH  serial data into stage 0
in_valid  input  1  valid bit shifted into stage 0 alongside in_data
load_data  input  WIDTH*DEPTH  parallel load image; stage k = bits [k*WIDTH +: WIDTH]
out_data  output  WIDTH  stage DEPTH-1 data (registered)
out_valid  output  1  stage DEPTH-1 valid bit
par_data  output  WIDTH*DEPTH  all stage data, same packing as load_data
occ  output  $clog2(DEPTH+1)  number of stages currently holding a valid bit
full  output  1  occ == DEPTH
empty  output  1  occ == 0

Behaviour:
- Clock is clk. Reset is synchronous and active-high on rst. The polarity and synchronicity are fixed.
- Reset: all stage data = 0, all valid bits = 0, occ = 0, so out_data = 0, out_valid = 0, full = 0, empty = 1. rst has priority over mode.
- HOLD: no state changes.
- SHIFT: stage 0 <= {in_data, in_valid}; stage k <= stage k-1 for k = 1..DEPTH-1. The old stage DEPTH-1 content is discarded. occ_next = occ + in_valid - vld[DEPTH-1].
- Latency: a word shifted in on edge n appears on out_data after DEPTH SHIFT edges. HOLD cycles do not count toward latency.
- LOAD: stage k data <= load_data slice k; all valid bits <= 1; occ <= DEPTH.
- CLEAR: same effect as reset, but it is mode-driven.
- Outputs are pure register reads with no combinational path from inputs. full and empty decode from occ.
- Boundaries:
  - SHIFT with in_valid=1 and last stage valid: occ unchanged. full stays 1 when already full.
  - SHIFT with in_valid=0 and last stage invalid: occ unchanged.
  - occ never exceeds DEPTH and never underflows. This holds by construction; the occ arithmetic is done at CNT_W+1 bits, and an assertion checks the bound.
  - in_data is captured regardless of in_valid, so invalid bubbles still carry data.
- No handshake or backpressure. The caller owns mode sequencing.

Optional Feature:
SHIFT_REG_TAP_EN.
- Defined:
  - Adds input tap_sel [$clog2(DEPTH)-1:0] and outputs tap_data [WIDTH-1:0] and tap_valid [1].
  - tap_data and tap_valid are registered copies of stage tap_sel, updated every cycle after the mode update. They reflect the stage contents one cycle late.
  - tap_sel >= DEPTH yields tap_data = 0 and tap_valid = 0.
  - Reset clears both outputs.
- Undefined: these ports are absent, and behaviour is otherwise identical.

Decomposition:
- Package shift_reg_pkg holds:
  - mode localparams MODE_HOLD=2'b00, MODE_SHIFT=2'b01, MODE_LOAD=2'b10, MODE_CLEAR=2'b11;
  - the function occ_w(depth) = $clog2(depth+1).
- Sub-module shift_stage: one {data, valid} register with synchronous clear, load and shift-enable inputs. It is instantiated DEPTH times in a generate loop; the top level holds the occ counter and the tap logic.

Test Plan:
- Reset, then SHIFT 10 cycles with in_valid=1 and in_data=1,0,1,1,0,0,1,0,1,1 (WIDTH=1, DEPTH=10) -> out_valid first rises after edge 10, out_data=1, occ=10, full=1.
- Single 1 shifted in (in_valid=1), then 9 SHIFT with in_data=0, in_valid=0 -> out_data=1 exactly on edge 10, 0 before and after; occ stays 1 until the word exits, then 0, empty=1.
- SHIFT, HOLD x5, SHIFT pattern -> HOLD cycles add no latency and par_data is unchanged during HOLD.
- LOAD with load_data=10'h2A5, then SHIFT x10 with in_valid=0 -> out_data sequence = stage 9..0 bits of 0x2A5; occ counts 10 down to 0.
- CLEAR mid-stream with occ=6, and rst asserted together with mode=LOAD -> all zero, occ=0; reset beats load.
- With SHIFT_REG_TAP_EN defined and tap_sel=3 after a known fill -> tap_data equals stage 3 one cycle later; tap_sel=12 -> tap_data=0, tap_valid=0.
